// File: rtl/fb_loader.sv
// ---------------------------------------------------------------------------
// fb_loader - byte-stream to framebuffer write engine.
//
// Parses packets received one byte at a time:
//     SYNC_BYTE, addr[15:8], addr[7:0], len, payload[len] (len 0 = 256 bytes)
// and issues one single-cycle RAM write for each payload byte. The write
// address starts at the packet address and wraps modulo 2**ADDR_W.
//
// Optional build macro FB_LOADER_CHECKSUM_EN:
//     adds a trailing checksum byte (XOR of addr_h, addr_l, len and every
//     payload byte). done pulses on a match and err pulses on a mismatch.
//     Without the macro there is no checksum byte, and done pulses together
//     with the final write.
//
// Ports:
//     clk        block clock, rising edge
//     reset      synchronous, active-low reset
//     rx_data    received byte, qualified by rx_valid
//     rx_valid   one-cycle strobe per received byte
//     ram_ce     RAM write strobe, one cycle per payload byte
//     ram_addr   RAM write address
//     ram_wdata  RAM write data
//     busy       high while a packet is in progress
//     done       one-cycle pulse when a packet completes
//     err        one-cycle pulse when a packet is aborted (timeout/checksum)
//
// State table:
//     state    | meaning
//     S_IDLE   | hunting for SYNC_BYTE, other bytes ignored
//     S_ADDR_H | waiting for address high byte
//     S_ADDR_L | waiting for address low byte
//     S_LEN    | waiting for length byte (0 = 256)
//     S_DATA   | each byte becomes one RAM write
//     S_CHK    | waiting for checksum byte (checksum build only)
// ---------------------------------------------------------------------------
module fb_loader #(
    parameter int          ADDR_W         = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 36000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              ram_ce,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN,
`ifdef FB_LOADER_CHECKSUM_EN
        S_DATA,
        S_CHK
`else
        S_DATA
`endif
    } state_t;

    state_t             state;
    logic [7:0]         addr_hi;
    logic [ADDR_W-1:0]  addr;
    logic [8:0]         remaining;
    // Down-counter: reloaded by every byte, a packet times out when it sits
    // at zero and no byte arrives. A byte on that same edge wins.
    logic [TMR_W-1:0]   tmr;
`ifdef FB_LOADER_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            addr_hi   <= '0;
            addr      <= '0;
            remaining <= '0;
            tmr       <= TMR_LOAD;
            ram_ce    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef FB_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            ram_ce <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;

            if (state == S_IDLE) begin
                tmr <= TMR_LOAD;
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state <= S_ADDR_H;
                    busy  <= 1'b1;
                end
            end else if (rx_valid) begin
                tmr <= TMR_LOAD;
                case (state)
                    S_ADDR_H: begin
                        addr_hi <= rx_data;
`ifdef FB_LOADER_CHECKSUM_EN
                        csum    <= rx_data;
`endif
                        state   <= S_ADDR_L;
                    end
                    S_ADDR_L: begin
                        // Upper address bits beyond ADDR_W are dropped here.
                        addr  <= ADDR_W'({addr_hi, rx_data});
`ifdef FB_LOADER_CHECKSUM_EN
                        csum  <= csum ^ rx_data;
`endif
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        remaining <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
`ifdef FB_LOADER_CHECKSUM_EN
                        csum      <= csum ^ rx_data;
`endif
                        state     <= S_DATA;
                    end
                    S_DATA: begin
                        ram_ce    <= 1'b1;
                        ram_addr  <= addr;
                        ram_wdata <= rx_data;
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - 9'd1;
`ifdef FB_LOADER_CHECKSUM_EN
                        csum      <= csum ^ rx_data;
                        if (remaining == 9'd1) begin
                            state <= S_CHK;
                        end
`else
                        if (remaining == 9'd1) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
`endif
                    end
`ifdef FB_LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (rx_data == csum) begin
                            done <= 1'b1;
                        end else begin
                            err  <= 1'b1;
                        end
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
`endif
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (tmr == '0) begin
                err   <= 1'b1;
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                tmr <= tmr - TMR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fb_loader.sv
// ---------------------------------------------------------------------------
// tb_fb_loader - directed self-checking bench for fb_loader.
// Bytes are driven on the falling edge, outputs sampled on the falling edge.
// A monitor logs every RAM write and counts done/err pulses.
// Timeout is shortened to TMO cycles to keep the run brief.
// ---------------------------------------------------------------------------
module tb_fb_loader;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        ram_ce;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        busy;
    logic        done;
    logic        err;

    fb_loader #(
        .ADDR_W         (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .ram_ce    (ram_ce),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int done_cnt = 0;
    int err_cnt = 0;
    int done_with_ce = 0;
    int both_cnt = 0;
    int run = 0;
    int max_run = 0;

    always @(negedge clk) begin
        if (ram_ce) begin
            wr_addr.push_back(ram_addr);
            wr_data.push_back(ram_wdata);
            run = run + 1;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (done) done_cnt = done_cnt + 1;
        if (err) err_cnt = err_cnt + 1;
        if (done && ram_ce) done_with_ce = done_with_ce + 1;
        if (done && err) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one rising edge; consecutive calls give
    // back-to-back rx_valid.
    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt     = 0;
        err_cnt      = 0;
        done_with_ce = 0;
        max_run      = 0;
    endtask

    initial begin
        int lat;
        int bad;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst ram_ce", {31'd0, ram_ce}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst ram_addr", {16'd0, ram_addr}, 32'd0);
        chk("rst ram_wdata", {24'd0, ram_wdata}, 32'd0);
        reset = 1'b1;
        idle(2);
        clear_log();

`ifdef FB_LOADER_CHECKSUM_EN
        // checksum = 00 ^ 00 ^ 01 ^ 0F = 0E
        put(8'hA5); idle(1); put(8'h00); idle(1); put(8'h00); idle(1);
        put(8'h01); idle(1); put(8'h0F); idle(1); put(8'h0E); idle(3);
        chk("cs ok writes", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("cs ok addr", {16'd0, wr_addr[0]}, 32'h0000);
            chk("cs ok data", {24'd0, wr_data[0]}, 32'h0F);
        end
        chk("cs ok done", done_cnt, 32'd1);
        chk("cs ok err", err_cnt, 32'd0);
        chk("cs ok done_with_ce", done_with_ce, 32'd0);
        clear_log();

        put(8'hA5); idle(1); put(8'h00); idle(1); put(8'h00); idle(1);
        put(8'h01); idle(1); put(8'h0F); idle(1); put(8'h00); idle(3);
        chk("cs bad writes", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("cs bad data", {24'd0, wr_data[0]}, 32'h0F);
        end
        chk("cs bad done", done_cnt, 32'd0);
        chk("cs bad err", err_cnt, 32'd1);
        chk("cs bad busy", {31'd0, busy}, 32'd0);
        clear_log();
`else
        // t1: basic three-byte packet, spaced bytes
        put(8'hA5);
        chk("t1 busy after sync", {31'd0, busy}, 32'd1);
        idle(1); put(8'h01); idle(1); put(8'h00); idle(1); put(8'h03); idle(1);
        put(8'h11); idle(1); put(8'h22); idle(1); put(8'h33); idle(3);
        chk("t1 writes", wr_addr.size(), 32'd3);
        if (wr_addr.size() == 3) begin
            chk("t1 addr0", {16'd0, wr_addr[0]}, 32'h0100);
            chk("t1 addr1", {16'd0, wr_addr[1]}, 32'h0101);
            chk("t1 addr2", {16'd0, wr_addr[2]}, 32'h0102);
            chk("t1 data0", {24'd0, wr_data[0]}, 32'h11);
            chk("t1 data1", {24'd0, wr_data[1]}, 32'h22);
            chk("t1 data2", {24'd0, wr_data[2]}, 32'h33);
        end
        chk("t1 done", done_cnt, 32'd1);
        chk("t1 done_with_ce", done_with_ce, 32'd1);
        chk("t1 err", err_cnt, 32'd0);
        chk("t1 busy end", {31'd0, busy}, 32'd0);
        clear_log();

        // t2: junk before sync is ignored
        put(8'h00); idle(1); put(8'hFF); idle(1); put(8'h5A); idle(1);
        chk("t2 busy junk", {31'd0, busy}, 32'd0);
        put(8'hA5); idle(1); put(8'h00); idle(1); put(8'h10); idle(1);
        put(8'h01); idle(1); put(8'h77); idle(3);
        chk("t2 writes", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t2 addr", {16'd0, wr_addr[0]}, 32'h0010);
            chk("t2 data", {24'd0, wr_data[0]}, 32'h77);
        end
        chk("t2 err", err_cnt, 32'd0);
        chk("t2 done", done_cnt, 32'd1);
        clear_log();

        // t3: back-to-back bytes, address wrap FFFF -> 0000
        put(8'hA5); put(8'hFF); put(8'hFF); put(8'h02); put(8'hAA); put(8'hBB);
        idle(3);
        chk("t3 writes", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("t3 addr0", {16'd0, wr_addr[0]}, 32'hFFFF);
            chk("t3 addr1", {16'd0, wr_addr[1]}, 32'h0000);
            chk("t3 data0", {24'd0, wr_data[0]}, 32'hAA);
            chk("t3 data1", {24'd0, wr_data[1]}, 32'hBB);
        end
        chk("t3 ce run", max_run, 32'd2);
        chk("t3 err", err_cnt, 32'd0);
        clear_log();

        // t4: len 0 means 256 bytes
        put(8'hA5); put(8'h00); put(8'h00); put(8'h00);
        for (int i = 0; i < 256; i++) put(i[7:0]);
        idle(3);
        chk("t4 writes", wr_addr.size(), 32'd256);
        bad = 0;
        if (wr_addr.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                if (wr_addr[i] != i[15:0] || wr_data[i] != i[7:0]) bad++;
            end
        end
        chk("t4 content", bad, 32'd0);
        chk("t4 done", done_cnt, 32'd1);
        chk("t4 done_with_ce", done_with_ce, 32'd1);
        clear_log();

        // t5: timeout mid-packet. Last byte accepted at edge E0; the counter
        // reaches its limit after TMO-1 further edges, so err is set on edge
        // E0+TMO and seen TMO falling edges after the byte.
        put(8'hA5); idle(1); put(8'h00); idle(1); put(8'h20); idle(1);
        put(8'h04); idle(1); put(8'h01); idle(1); put(8'h02);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!err && lat < 4 * TMO);
        chk("t5 err latency", lat, TMO);
        idle(2);
        chk("t5 writes", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("t5 addr1", {16'd0, wr_addr[1]}, 32'h0021);
        end
        chk("t5 err", err_cnt, 32'd1);
        chk("t5 done", done_cnt, 32'd0);
        chk("t5 busy", {31'd0, busy}, 32'd0);
        clear_log();

        // t6: byte arriving on the limit edge beats the timeout
        put(8'hA5); idle(1); put(8'h00); idle(1); put(8'h30); idle(1); put(8'h02);
        idle(TMO - 1); put(8'h55);
        idle(TMO - 1); put(8'h66);
        idle(3);
        chk("t6 writes", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("t6 data1", {24'd0, wr_data[1]}, 32'h66);
        end
        chk("t6 err", err_cnt, 32'd0);
        chk("t6 done", done_cnt, 32'd1);
        clear_log();

        // t7: reset mid-DATA drops the packet silently
        put(8'hA5); idle(1); put(8'h00); idle(1); put(8'h40); idle(1);
        put(8'h04); idle(1); put(8'h01); idle(1); put(8'h02);
        reset = 1'b0;
        @(negedge clk);
        chk("t7 rst ram_ce", {31'd0, ram_ce}, 32'd0);
        chk("t7 rst busy", {31'd0, busy}, 32'd0);
        chk("t7 rst addr", {16'd0, ram_addr}, 32'd0);
        chk("t7 rst wdata", {24'd0, ram_wdata}, 32'd0);
        reset = 1'b1;
        idle(2);
        put(8'h03); idle(1); put(8'h04); idle(3);
        chk("t7 writes", wr_addr.size(), 32'd2);
        chk("t7 err", err_cnt, 32'd0);
        chk("t7 done", done_cnt, 32'd0);
        chk("t7 busy", {31'd0, busy}, 32'd0);
        clear_log();
`endif

        chk("done_err_overlap", both_cnt, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
